// File: rtl/openfire_rf_wb_ctrl.sv
`default_nettype none
//==============================================================================
// Module : openfire_rf_wb_ctrl
// Desc   : Register-file write-port scheduler: arbitrates execute writes against
//          in-order load returns, tracks pending loads, raises hazard stalls.
//          Build option OPENFIRE_RF_CLEAR_ALL_EN clears r0..r31 after reset.
// Rev    : 1.0  initial release
//==============================================================================

`ifndef RF_dmem_byte
`define RF_dmem_byte      4'd0
`define RF_dmem_halfword  4'd1
`define RF_dmem_wholeword 4'd2
`define RF_alu_result     4'd3
`define RF_zero           4'd4
`define RF_pc             4'd5
`endif

module openfire_rf_wb_ctrl #(
    parameter int LDQ_DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ex_we,
    input  logic [4:0] ex_addr,
    input  logic [3:0] ex_sel,
    input  logic       ld_issue,
    input  logic [4:0] ld_addr,
    input  logic [3:0] ld_sel,
    input  logic       dmem_valid,
    input  logic [4:0] dec_regA_addr,
    input  logic [4:0] dec_regB_addr,
    input  logic [4:0] dec_regD_addr,
    input  logic [2:0] dec_use,
    output logic       rf_we,
    output logic [4:0] rf_waddr,
    output logic [3:0] rf_sel,
    output logic       ex_stall,
    output logic       ld_stall,
    output logic       hazard_stall,
    output logic       busy,
    output logic       wb_err
);

    localparam int c_PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(LDQ_DEPTH) + 1;

`ifdef OPENFIRE_RF_CLEAR_ALL_EN
    localparam logic [4:0] c_SWEEP_LAST = 5'd31;
`else
    localparam logic [4:0] c_SWEEP_LAST = 5'd0;
`endif

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [4:0]           r_sweep;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [LDQ_DEPTH-1:0] r_vld;
    logic [4:0]           r_addr [LDQ_DEPTH];
    logic [3:0]           r_sel  [LDQ_DEPTH];
    logic                 r_err;

    logic       w_run;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_ex_hit;
    logic       w_dec_hit;
    logic       w_err_set;
    logic [4:0] w_dec_addr [3];

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(LDQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_run   = ~reset & (r_state == ST_RUN);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(LDQ_DEPTH));
    assign w_pop   = w_run & dmem_valid & ~w_empty;
    assign w_push  = w_run & ld_issue & ~w_full;

    assign w_dec_addr[0] = dec_regA_addr;
    assign w_dec_addr[1] = dec_regB_addr;
    assign w_dec_addr[2] = dec_regD_addr;

    // Every valid entry counts, including the head popped this cycle:
    // the popped value only lands in the file at the coming edge.
    always_comb begin
        w_ex_hit  = 1'b0;
        w_dec_hit = 1'b0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (r_vld[i] && ex_addr != 5'd0 && r_addr[i] == ex_addr)
                w_ex_hit = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (dec_use[k] && w_dec_addr[k] != 5'd0 && r_vld[i] &&
                    r_addr[i] == w_dec_addr[k])
                    w_dec_hit = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (dec_use[k] && w_dec_addr[k] != 5'd0 && w_push &&
                ld_addr == w_dec_addr[k])
                w_dec_hit = 1'b1;
        end
    end

    assign w_err_set = w_run & ((dmem_valid & w_empty) |
                                (ld_issue & w_full) |
                                (ex_we & (ex_sel != `RF_alu_result) &
                                         (ex_sel != `RF_pc)));

    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_sel       = `RF_zero;
        ex_stall     = 1'b0;
        ld_stall     = 1'b0;
        hazard_stall = 1'b0;
        busy         = 1'b0;
        if (!w_run) begin
            rf_we        = 1'b1;
            rf_waddr     = reset ? 5'd0 : r_sweep;
            ex_stall     = 1'b1;
            ld_stall     = 1'b1;
            hazard_stall = 1'b1;
            busy         = 1'b1;
        end else begin
            ld_stall     = w_full;
            hazard_stall = w_dec_hit;
            ex_stall     = ex_we & (w_pop | w_ex_hit);
            if (w_pop) begin
                rf_we    = (r_addr[r_head] != 5'd0);
                rf_waddr = r_addr[r_head];
                rf_sel   = r_sel[r_head];
            end else if (ex_we && !ex_stall) begin
                rf_we    = (ex_addr != 5'd0);
                rf_waddr = ex_addr;
                rf_sel   = ex_sel;
            end
        end
    end

    assign wb_err = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_sweep <= 5'd0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ST_INIT) begin
            if (r_sweep == c_SWEEP_LAST) begin
                r_state <= ST_RUN;
                r_sweep <= 5'd0;
            end else begin
                r_sweep <= r_sweep + 5'd1;
            end
        end else begin
            // Push and pop never share a slot: pop needs non-empty, push non-full.
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= f_next(r_head);
            end
            if (w_push) begin
                r_vld[r_tail]  <= 1'b1;
                r_addr[r_tail] <= ld_addr;
                r_sel[r_tail]  <= ld_sel;
                r_tail         <= f_next(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_err_set)
                r_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_openfire_rf_wb_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_openfire_rf_wb_ctrl
// Desc   : Directed scenarios plus random traffic against a queue-based model.
// Rev    : 1.0  initial release
//==============================================================================

`ifndef RF_dmem_byte
`define RF_dmem_byte      4'd0
`define RF_dmem_halfword  4'd1
`define RF_dmem_wholeword 4'd2
`define RF_alu_result     4'd3
`define RF_zero           4'd4
`define RF_pc             4'd5
`endif

module tb_openfire_rf_wb_ctrl;

    localparam int LDQ_DEPTH = 2;
`ifdef OPENFIRE_RF_CLEAR_ALL_EN
    localparam int c_INIT_LEN = 32;
`else
    localparam int c_INIT_LEN = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ex_we, ld_issue, dmem_valid;
    logic [4:0] ex_addr, ld_addr, dec_regA_addr, dec_regB_addr, dec_regD_addr;
    logic [3:0] ex_sel, ld_sel;
    logic [2:0] dec_use;
    logic       rf_we, ex_stall, ld_stall, hazard_stall, busy, wb_err;
    logic [4:0] rf_waddr;
    logic [3:0] rf_sel;

    always #5 clock = ~clock;

    openfire_rf_wb_ctrl #(.LDQ_DEPTH(LDQ_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .ex_we(ex_we), .ex_addr(ex_addr), .ex_sel(ex_sel),
        .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_sel(ld_sel),
        .dmem_valid(dmem_valid),
        .dec_regA_addr(dec_regA_addr), .dec_regB_addr(dec_regB_addr),
        .dec_regD_addr(dec_regD_addr), .dec_use(dec_use),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_sel(rf_sel),
        .ex_stall(ex_stall), .ld_stall(ld_stall), .hazard_stall(hazard_stall),
        .busy(busy), .wb_err(wb_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending loads as a plain FIFO of {dest, width}.
    typedef struct packed {logic [4:0] a; logic [3:0] s;} ld_t;
    ld_t  m_q[$];
    bit   m_init  = 1'b1;
    int   m_sweep = 0;
    bit   m_err   = 1'b0;
    bit   m_pop, m_push;
    logic       e_we, e_exs, e_lds, e_hz, e_busy;
    logic [4:0] e_waddr;
    logic [3:0] e_sel;

    task automatic idle();
        ex_we = 0; ex_addr = 0; ex_sel = `RF_alu_result;
        ld_issue = 0; ld_addr = 0; ld_sel = `RF_dmem_wholeword;
        dmem_valid = 0; dec_use = 0;
        dec_regA_addr = 0; dec_regB_addr = 0; dec_regD_addr = 0;
    endtask

    task automatic eval();
        logic [4:0] da [3];
        bit hit_ex;
        #2;
        m_pop = 0; m_push = 0; hit_ex = 0;
        da[0] = dec_regA_addr; da[1] = dec_regB_addr; da[2] = dec_regD_addr;
        if (reset || m_init) begin
            e_we = 1; e_waddr = reset ? 5'd0 : 5'(m_sweep); e_sel = `RF_zero;
            e_exs = 1; e_lds = 1; e_hz = 1; e_busy = 1;
        end else begin
            m_pop  = dmem_valid && m_q.size() > 0;
            m_push = ld_issue && m_q.size() < LDQ_DEPTH;
            foreach (m_q[i]) if (ex_addr != 0 && m_q[i].a == ex_addr) hit_ex = 1;
            e_exs = ex_we && (m_pop || hit_ex);
            e_lds = (m_q.size() == LDQ_DEPTH);
            e_busy = 0;
            e_hz = 0;
            for (int k = 0; k < 3; k++) begin
                if (dec_use[k] && da[k] != 0) begin
                    foreach (m_q[i]) if (m_q[i].a == da[k]) e_hz = 1;
                    if (m_push && ld_addr == da[k]) e_hz = 1;
                end
            end
            if (m_pop) begin
                e_we = (m_q[0].a != 0); e_waddr = m_q[0].a; e_sel = m_q[0].s;
            end else if (ex_we && !e_exs) begin
                e_we = (ex_addr != 0); e_waddr = ex_addr; e_sel = ex_sel;
            end else begin
                e_we = 0; e_waddr = 0; e_sel = `RF_zero;
            end
        end
        check("outputs{we,waddr,sel,exs,lds,hz,busy,err}",
              {rf_we, rf_waddr, rf_sel, ex_stall, ld_stall, hazard_stall, busy, wb_err},
              {e_we, e_waddr, e_sel, e_exs, e_lds, e_hz, e_busy, m_err});
    endtask

    task automatic adv();
        if (reset) begin
            m_init = 1; m_sweep = 0; m_q.delete(); m_err = 0;
        end else if (m_init) begin
            if (m_sweep == c_INIT_LEN - 1) begin
                m_init = 0; m_sweep = 0;
            end else begin
                m_sweep++;
            end
        end else begin
            if ((dmem_valid && m_q.size() == 0) ||
                (ld_issue && m_q.size() == LDQ_DEPTH) ||
                (ex_we && ex_sel != `RF_alu_result && ex_sel != `RF_pc))
                m_err = 1;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back('{a: ld_addr, s: ld_sel});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    task automatic do_reset();
        idle();
        reset = 1; cyc();
        reset = 0;
        repeat (c_INIT_LEN) cyc();
    endtask

    task automatic rand_inputs();
        int r;
        reset = ($urandom_range(0, 199) == 0);
        ex_we = $urandom_range(0, 1);
        ex_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        r = $urandom_range(0, 49);
        ex_sel = (r == 0) ? 4'd7 : (r[0] ? `RF_alu_result : `RF_pc);
        ld_issue = ($urandom_range(0, 9) < 3);
        ld_addr = 5'($urandom_range(0, 7));
        ld_sel = 4'($urandom_range(0, 2));
        dmem_valid = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
        dec_use = 3'($urandom_range(0, 7));
        dec_regA_addr = 5'($urandom_range(0, 7));
        dec_regB_addr = 5'($urandom_range(0, 7));
        dec_regD_addr = 5'($urandom_range(0, 7));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        @(posedge clock); #1;

        // Reset and initialisation sweep
        eval(); check("reset_busy", busy, 1); check("reset_waddr", rf_waddr, 0); adv();
        reset = 0;
        for (int i = 0; i < c_INIT_LEN; i++) begin
            eval();
            check("init_write", {rf_we, rf_waddr, rf_sel, busy}, {1'b1, 5'(i), `RF_zero, 1'b1});
            adv();
        end
        eval(); check("busy_done", busy, 0); adv();

        // Load return preempts a held execute write
        ld_issue = 1; ld_addr = 5; ld_sel = `RF_dmem_wholeword; cyc();
        idle(); ex_we = 1; ex_addr = 7;
        eval(); check("ex_r7", {rf_we, rf_waddr, rf_sel}, {1'b1, 5'd7, `RF_alu_result}); adv();
        idle(); cyc(); cyc();
        dmem_valid = 1; ex_we = 1; ex_addr = 9;
        eval();
        check("ld_r5", {rf_we, rf_waddr, rf_sel}, {1'b1, 5'd5, `RF_dmem_wholeword});
        check("ex_stall_ret", ex_stall, 1);
        adv();
        dmem_valid = 0;
        eval(); check("ex_r9", {rf_we, rf_waddr, ex_stall}, {1'b1, 5'd9, 1'b0}); adv();

        // RAW hazard through the return cycle; r0 never hazards
        idle(); ld_issue = 1; ld_addr = 3; ld_sel = `RF_dmem_byte;
        dec_use = 3'b001; dec_regA_addr = 3;
        eval(); check("hz_issue", hazard_stall, 1); adv();
        ld_issue = 0; eval(); check("hz_pend", hazard_stall, 1); adv();
        dmem_valid = 1;
        eval(); check("hz_ret", hazard_stall, 1);
        check("ld_r3", {rf_we, rf_waddr, rf_sel}, {1'b1, 5'd3, `RF_dmem_byte}); adv();
        dmem_valid = 0; eval(); check("hz_clear", hazard_stall, 0); adv();
        ld_issue = 1; ld_addr = 0; dec_regA_addr = 0;
        eval(); check("hz_r0_issue", hazard_stall, 0); adv();
        ld_issue = 0; eval(); check("hz_r0_pend", hazard_stall, 0); adv();
        dmem_valid = 1; eval(); check("ld_r0_nowrite", rf_we, 0); adv();

        // Queue full, simultaneous return and stalled issue
        idle(); ld_issue = 1; ld_addr = 1; cyc();
        ld_addr = 2; cyc();
        ld_issue = 0; eval(); check("ldq_full", ld_stall, 1); adv();
        dmem_valid = 1; ld_issue = 1; ld_addr = 4;
        eval(); check("full_ret_stall", ld_stall, 1);
        check("full_ret_r1", {rf_we, rf_waddr}, {1'b1, 5'd1}); adv();
        idle(); eval(); check("ldq_freed", ld_stall, 0); adv();
        dmem_valid = 1; cyc();
        do_reset();

        // WAW guard holds the ALU write until the load lands
        idle(); ld_issue = 1; ld_addr = 6; cyc();
        idle(); ex_we = 1; ex_addr = 6;
        eval(); check("waw_stall", ex_stall, 1); adv();
        cyc();
        dmem_valid = 1;
        eval(); check("waw_ret", {rf_we, rf_waddr, ex_stall}, {1'b1, 5'd6, 1'b1}); adv();
        dmem_valid = 0;
        eval(); check("waw_go", {rf_we, rf_waddr, rf_sel, ex_stall}, {1'b1, 5'd6, `RF_alu_result, 1'b0}); adv();

        // Spurious return sets a sticky error
        idle(); dmem_valid = 1;
        eval(); check("spur_nowrite", rf_we, 0); check("err_before", wb_err, 0); adv();
        idle(); eval(); check("err_set", wb_err, 1); adv();
        repeat (3) cyc();
        eval(); check("err_sticky", wb_err, 1); adv();
        do_reset();
        eval(); check("err_cleared", wb_err, 0); adv();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
